// File: rtl/uart_tx_8n1_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_8n1_if
// Description : Byte handshake between a producer and the UART transmitter.
//               The producer drives tx_data/tx_valid; the transmitter answers
//               with tx_ready. A byte moves on an edge where both are high.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_8n1_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    // Producer side
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    // Transmitter side
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_8n1.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_8n1
// Description : Byte-serial asynchronous transmitter. Accepts a byte over a
//               valid/ready handshake and shifts it out LSB first framed by
//               a start bit, optional parity bit and one or two stop bits.
//               The serial line is registered and idles high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 138,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  wire logic      pin3_clk_16mhz,
    input  wire logic      reset,
    uart_tx_8n1_if.slave   s_tx,
    output logic           tx,
    output logic           busy
);

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx_8n1: CLKS_PER_BIT must be >= 2");
        end
        if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
            $error("uart_tx_8n1: PARITY must be 0, 1 or 2");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
            $error("uart_tx_8n1: STOP_BITS must be 1 or 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int                c_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic              c_HAS_PAR   = (PARITY != 0);
    localparam logic              c_ODD_PAR   = (PARITY == 2);
    localparam logic              c_LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic [2:0]           r_idx;
    logic [2:0]           w_idx_next;
    logic                 r_stop_idx;
    logic                 w_stop_idx_next;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_next;
    logic                 r_par;
    logic                 w_par_next;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 r_ready;
    logic                 w_ready_next;

    logic                 w_handshake;
    logic                 w_bit_end;

    assign w_handshake = s_tx.tx_valid & r_ready;
    assign w_bit_end   = (r_cnt == c_CNT_MAX);

    // Next-state, baud counter, shift register and next line level
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt + c_CNT_ONE;
        w_idx_next      = r_idx;
        w_stop_idx_next = r_stop_idx;
        w_shift_next    = r_shift;
        w_par_next      = r_par;
        w_tx_next       = r_tx;

        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                w_tx_next  = 1'b1;
                if (w_handshake) begin
                    // Start bit appears on the same edge the byte is taken
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                    w_shift_next = s_tx.tx_data;
                    w_par_next   = (^s_tx.tx_data) ^ c_ODD_PAR;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_cnt_next   = '0;
                    w_idx_next   = 3'd0;
                    w_tx_next    = r_shift[0];
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_idx == 3'd7) begin
                        if (c_HAS_PAR) begin
                            w_state_next = S_PARITY;
                            w_tx_next    = r_par;
                        end else begin
                            w_state_next    = S_STOP;
                            w_tx_next       = 1'b1;
                            w_stop_idx_next = 1'b0;
                        end
                    end else begin
                        // Shift and present the following bit in one step
                        w_idx_next   = r_idx + 3'd1;
                        w_shift_next = {1'b0, r_shift[7:1]};
                        w_tx_next    = r_shift[1];
                    end
                end
            end

            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next    = S_STOP;
                    w_cnt_next      = '0;
                    w_tx_next       = 1'b1;
                    w_stop_idx_next = 1'b0;
                end
            end

            S_STOP: begin
                w_tx_next = 1'b1;
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_stop_idx == c_LAST_STOP) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_stop_idx_next = 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // Ready is registered so it stays low through reset and rises one edge later
    assign w_ready_next = (w_state_next == S_IDLE);

    // State register; reset wins over any simultaneous handshake
    always_ff @(posedge pin3_clk_16mhz) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= 3'd0;
            r_stop_idx <= 1'b0;
            r_shift    <= 8'h00;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_idx      <= w_idx_next;
            r_stop_idx <= w_stop_idx_next;
            r_shift    <= w_shift_next;
            r_par      <= w_par_next;
            r_tx       <= w_tx_next;
            r_ready    <= w_ready_next;
        end
    end

    assign tx             = r_tx;
    assign busy           = (r_state != S_IDLE);
    assign s_tx.tx_ready  = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_8n1.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_8n1
// Description : Directed bench for uart_tx_8n1. Four instances cover 8N1,
//               even parity, odd parity with two stop bits, and the default
//               138-clock bit time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_8n1;

    localparam int c_CPB     = 4;
    localparam int c_HS_WAIT = 2000;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    uart_tx_8n1_if if_a ();
    uart_tx_8n1_if if_b ();
    uart_tx_8n1_if if_c ();
    uart_tx_8n1_if if_d ();

    logic tx_a, tx_b, tx_c, tx_d;
    logic busy_a, busy_b, busy_c, busy_d;

    uart_tx_8n1 #(.CLKS_PER_BIT(c_CPB), .PARITY(0), .STOP_BITS(1)) u_a (
        .pin3_clk_16mhz(clk), .reset(rst), .s_tx(if_a), .tx(tx_a), .busy(busy_a));
    uart_tx_8n1 #(.CLKS_PER_BIT(c_CPB), .PARITY(1), .STOP_BITS(1)) u_b (
        .pin3_clk_16mhz(clk), .reset(rst), .s_tx(if_b), .tx(tx_b), .busy(busy_b));
    uart_tx_8n1 #(.CLKS_PER_BIT(c_CPB), .PARITY(2), .STOP_BITS(2)) u_c (
        .pin3_clk_16mhz(clk), .reset(rst), .s_tx(if_c), .tx(tx_c), .busy(busy_c));
    uart_tx_8n1 u_d (
        .pin3_clk_16mhz(clk), .reset(rst), .s_tx(if_d), .tx(tx_d), .busy(busy_d));

    logic cap  [0:2047];
    logic bcap [0:2047];
    logic rcap [0:2047];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_tx(input int sel);
        case (sel)
            0:       return tx_a;
            1:       return tx_b;
            2:       return tx_c;
            default: return tx_d;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return busy_a;
            1:       return busy_b;
            2:       return busy_c;
            default: return busy_d;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0:       return if_a.tx_ready;
            1:       return if_b.tx_ready;
            2:       return if_c.tx_ready;
            default: return if_d.tx_ready;
        endcase
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        case (sel)
            0:       begin if_a.tx_valid = v; if_a.tx_data = d; end
            1:       begin if_b.tx_valid = v; if_b.tx_data = d; end
            2:       begin if_c.tx_valid = v; if_c.tx_data = d; end
            default: begin if_d.tx_valid = v; if_d.tx_data = d; end
        endcase
    endtask

    // Present a byte, wait for ready, and take the handshake edge
    task automatic send(input int sel, input logic [7:0] d, input bit hold);
        int k;
        drive(sel, 1'b1, d);
        k = 0;
        while (get_ready(sel) !== 1'b1 && k < c_HS_WAIT) begin
            tick();
            k++;
        end
        check("hs_wait_in_bound", 32'(k < c_HS_WAIT), 32'd1);
        tick();
        if (!hold) drive(sel, 1'b0, d);
    endtask

    // Record n samples, one per cycle, starting at the current cycle
    task automatic capture(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            cap[i]  = get_tx(sel);
            bcap[i] = get_busy(sel);
            rcap[i] = get_ready(sel);
            tick();
        end
    endtask

    // Expected line level for frame bit position j
    function automatic logic frame_bit(input logic [7:0] d, input int par, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        if (j == 9 && par == 1) return ^d;
        if (j == 9 && par == 2) return ~^d;
        return 1'b1;
    endfunction

    // Capture a whole frame right after its handshake and compare to the model
    task automatic check_frame(input int sel, input logic [7:0] d, input int par,
                               input int stops, input int cpb);
        int nb;
        int f;
        int nbusy;
        nb = 9 + ((par != 0) ? 1 : 0) + stops;
        f  = nb * cpb;
        capture(sel, f);
        nbusy = 0;
        for (int i = 0; i < f; i++) begin
            check($sformatf("tx_s%0d_%02h_i%0d", sel, d, i), 32'(cap[i]),
                  32'(frame_bit(d, par, i / cpb)));
            if (bcap[i] === 1'b1) nbusy++;
        end
        check("busy_cycles", 32'(nbusy), 32'(f));
        check("ready_low_last_cycle", 32'(rcap[f-1]), 32'd0);
        check("end_ready", 32'(get_ready(sel)), 32'd1);
        check("end_busy", 32'(get_busy(sel)), 32'd0);
        check("end_tx", 32'(get_tx(sel)), 32'd1);
    endtask

    initial begin
        int trans [$];
        int exp_trans [7];
        logic [7:0] ref_byte;
        int idx;

        exp_trans = '{138, 414, 552, 690, 966, 1104, 1242};

        rst = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        drive(3, 1'b0, 8'h00);

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_tx", 32'(tx_a), 32'd1);
            check("rst_ready", 32'(if_a.tx_ready), 32'd0);
            check("rst_busy", 32'(busy_a), 32'd0);
        end
        rst = 1'b0;
        check("ready_before_release_edge", 32'(if_a.tx_ready), 32'd0);
        tick();
        check("ready_after_release", 32'(if_a.tx_ready), 32'd1);
        check("ready_d_after_release", 32'(if_d.tx_ready), 32'd1);
        check("idle_tx", 32'(tx_a), 32'd1);

        // 0x55, 8N1
        send(0, 8'h55, 1'b0);
        check_frame(0, 8'h55, 0, 1, c_CPB);

        // Back-to-back 0xA3 then 0x0F, valid held high
        send(0, 8'hA3, 1'b1);
        drive(0, 1'b1, 8'h0F);
        capture(0, 41);
        for (int i = 0; i < 40; i++)
            check($sformatf("b2b_a3_i%0d", i), 32'(cap[i]), 32'(frame_bit(8'hA3, 0, i / c_CPB)));
        check("b2b_gap_idle", 32'(cap[40]), 32'd1);
        drive(0, 1'b0, 8'h0F);
        check_frame(0, 8'h0F, 0, 1, c_CPB);

        // Even parity, 0x07 -> parity bit 1
        send(1, 8'h07, 1'b0);
        check_frame(1, 8'h07, 1, 1, c_CPB);
        check("even_par_07", 32'(cap[36]), 32'd1);

        // Odd parity, two stop bits, 0x07 -> parity bit 0, frame 48 cycles
        send(2, 8'h07, 1'b0);
        check_frame(2, 8'h07, 2, 2, c_CPB);
        check("odd_par_07", 32'(cap[36]), 32'd0);
        check("two_stop_first", 32'(cap[40]), 32'd1);
        check("two_stop_last", 32'(cap[47]), 32'd1);

        // Reset during data bit 3 of 0xFF
        send(0, 8'hFF, 1'b0);
        capture(0, 17);
        check("in_bit3_busy", 32'(busy_a), 32'd1);
        rst = 1'b1;
        tick();
        check("abort_tx", 32'(tx_a), 32'd1);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_ready", 32'(if_a.tx_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("abort_ready_after", 32'(if_a.tx_ready), 32'd1);
        send(0, 8'h00, 1'b0);
        check_frame(0, 8'h00, 0, 1, c_CPB);

        // Reset coincident with a handshake: reset wins
        drive(0, 1'b1, 8'h5A);
        rst = 1'b1;
        tick();
        check("rst_hs_tx", 32'(tx_a), 32'd1);
        check("rst_hs_busy", 32'(busy_a), 32'd0);
        drive(0, 1'b0, 8'h5A);
        rst = 1'b0;
        tick();
        check("rst_hs_idle_tx", 32'(tx_a), 32'd1);
        check("rst_hs_ready", 32'(if_a.tx_ready), 32'd1);

        // Default 138 clocks per bit, 0x4B
        send(3, 8'h4B, 1'b0);
        check_frame(3, 8'h4B, 0, 1, 138);
        for (int i = 1; i < 1380; i++)
            if (cap[i] !== cap[i-1]) trans.push_back(i);
        check("edges_4b_count", 32'(trans.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < trans.size())
                check($sformatf("edge_4b_%0d", i), 32'(trans[i]), 32'(exp_trans[i]));
        end
        // Receiver at 115200 baud samples each bit centre from the start edge
        ref_byte = 8'h00;
        for (int k = 0; k < 8; k++) begin
            idx = ((2 * (k + 1) + 1) * 16000000) / 230400;
            ref_byte[k] = cap[idx];
        end
        check("ref_rx_byte", 32'(ref_byte), 32'h4B);
        idx = (19 * 16000000) / 230400;
        check("ref_rx_stop", 32'(cap[idx]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
